mem_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction-fetch and data requesters of the core.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch; a watchdog aborts hung accesses.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramREADY,
  output logic  bus_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);

  arb_state_t          state_q;
  word_t               addr_q;
  word_t               store_q;
  logic                ren_q;
  logic                wen_q;
  logic                bus_err_q;
  logic [STARVE_W-1:0] starve_q;
  logic [WDOG_W-1:0]   wdog_q;

  logic                d_req_c;
  logic                starved_c;
  logic                granted_c;
  logic                expire_c;
  logic [STARVE_W-1:0] starve_inc_c;
  logic                ihit_c;
  logic                dhit_c;

  assign d_req_c      = dREN | dWEN;
  assign starved_c    = iREN && (starve_q == STARVE_W'(STARVE_MAX));
  assign granted_c    = (state_q != IDLE);
  assign expire_c     = granted_c && !ramREADY && (wdog_q == WDOG_W'(TIMEOUT - 1));
  assign starve_inc_c = (starve_q == STARVE_W'(STARVE_MAX)) ? starve_q
                                                            : starve_q + STARVE_W'(1);

  // Arbitration FSM with request latching, starvation counter and watchdog.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      bus_err_q <= 1'b0;
      starve_q  <= '0;
      wdog_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req_c && !starved_c) begin
            state_q  <= DGRANT;
            addr_q   <= daddr;
            store_q  <= dstore;
            wen_q    <= dWEN;
            ren_q    <= dREN & ~dWEN;
            wdog_q   <= '0;
            starve_q <= iREN ? starve_inc_c : '0;
          end else if (iREN) begin
            state_q  <= IGRANT;
            addr_q   <= iaddr;
            wen_q    <= 1'b0;
            ren_q    <= 1'b1;
            wdog_q   <= '0;
            starve_q <= '0;
          end
        end
        DGRANT, IGRANT: begin
          if (ramREADY) begin
            state_q <= IDLE;
          end else if (expire_c) begin
            state_q   <= IDLE;
            bus_err_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes come only from the state and latched request registers.
  assign ramREN   = granted_c & ren_q;
  assign ramWEN   = granted_c & wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Completion is combinational on ramREADY so the hit lands in the RAM's completion cycle.
  assign ihit_c  = (state_q == IGRANT) & ramREADY;
  assign dhit_c  = (state_q == DGRANT) & ramREADY;
  assign ihit    = ihit_c;
  assign dhit    = dhit_c;
  assign iload   = ihit_c ? ramload : '0;
  assign dload   = dhit_c ? ramload : '0;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned SM = 4;
  localparam int unsigned TO = 64;

  logic  CLK = 1'b0;
  logic  RST;
  logic  iREN, dREN, dWEN, ramREADY;
  word_t iaddr, daddr, dstore, ramload;
  logic  ihit, dhit, ramREN, ramWEN, bus_err;
  word_t iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramREADY(ramREADY), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how long it has waited, fetch-starvation tally.
  int           m_owner;   // 0 none, 1 data, 2 fetch
  int           m_waited;  // grant cycles that passed without ramREADY
  int           m_dwins;   // data grants in a row while a fetch was waiting
  bit           m_err;
  bit           m_write;
  logic [31:0]  m_addr, m_store;

  always @(posedge CLK) begin
    if (RST) begin
      m_owner = 0; m_waited = 0; m_dwins = 0; m_err = 0; m_write = 0;
      m_addr = 0; m_store = 0;
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && !(iREN && m_dwins >= SM)) begin
        m_owner = 1; m_waited = 0; m_addr = daddr; m_store = dstore; m_write = dWEN;
        m_dwins = iREN ? ((m_dwins + 1 > SM) ? SM : m_dwins + 1) : 0;
      end else if (iREN) begin
        m_owner = 2; m_waited = 0; m_addr = iaddr; m_dwins = 0;
      end
    end else if (ramREADY) begin
      m_owner = 0;
    end else if (m_waited + 1 >= TO) begin
      m_owner = 0; m_err = 1;
    end else begin
      m_waited++;
    end
  end

  // Compare process and cumulative monitors, sampled on the falling edge.
  bit   check_en = 0;
  bit   last_ihit, last_dhit;
  int   cyc = 0, n_ren = 0, n_ihit = 0, n_dhit = 0;
  byte  hit_q[$];
  int   hit_cyc[$];

  always @(negedge CLK) begin
    cyc++;
    last_ihit = ihit;
    last_dhit = dhit;
    if (check_en) begin
      chk("ramREN", ramREN, (m_owner == 2 || (m_owner == 1 && !m_write)) ? 1 : 0);
      chk("ramWEN", ramWEN, (m_owner == 1 && m_write) ? 1 : 0);
      chk("ihit", ihit, (m_owner == 2 && ramREADY) ? 1 : 0);
      chk("dhit", dhit, (m_owner == 1 && ramREADY) ? 1 : 0);
      chk("hit_excl", ihit & dhit, 0);
      chk("bus_err", bus_err, m_err);
      if (m_owner != 0) chk("ramaddr", ramaddr, m_addr);
      if (m_owner == 1 && m_write) chk("ramstore", ramstore, m_store);
      if (m_owner == 2 && ramREADY) chk("iload", iload, ramload);
      if (m_owner == 1 && ramREADY) chk("dload", dload, ramload);
    end
    if (ramREN === 1'b1) n_ren++;
    if (ihit === 1'b1) begin n_ihit++; hit_q.push_back("I"); hit_cyc.push_back(cyc); end
    if (dhit === 1'b1) begin n_dhit++; hit_q.push_back("D"); hit_cyc.push_back(cyc); end
  end

  bit auto_rel = 0;
  bit rnd      = 0;

  task automatic step();
    @(posedge CLK); #1;
    if (auto_rel) begin
      if (last_ihit) iREN = 1'b0;
      if (last_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
    end
    if (rnd) begin
      RST = ($urandom % 300 == 0);
      if (!iREN && ($urandom % 3 == 0)) begin iREN = 1'b1; iaddr = $urandom; end
      if (!dREN && !dWEN && ($urandom % 3 == 0)) begin
        int k;
        k = $urandom % 3;
        dREN = (k != 1); dWEN = (k != 0); daddr = $urandom; dstore = $urandom;
      end
      ramREADY = ($urandom % 4 != 0);
      ramload  = $urandom;
    end
  endtask

  task automatic sample();
    @(negedge CLK); #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramREADY = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  task automatic do_reset();
    auto_rel = 0; rnd = 0;
    clear_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    sample();
  endtask

  int    b_ren, b_ihit, b_dhit, b_hq;
  string exp_order;

  initial begin
    RST = 1'b1;
    clear_inputs();
    step(); step();
    check_en = 1;
    RST = 1'b0;
    sample();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);

    // Lone fetch, RAM ready on the 3rd grant cycle.
    b_ren = n_ren; b_ihit = n_ihit; b_dhit = n_dhit;
    iREN = 1; iaddr = 32'h40;
    step(); step(); step();
    ramREADY = 1; ramload = 32'h8C220004;
    sample();
    chk("t1_ihit", ihit, 1);
    chk("t1_iload", iload, 32'h8C220004);
    chk("t1_ramaddr", ramaddr, 32'h40);
    step();
    iREN = 0; ramREADY = 0;
    repeat (3) step();
    sample();
    chk("t1_ren_cycles", n_ren - b_ren, 3);
    chk("t1_ihit_count", n_ihit - b_ihit, 1);
    chk("t1_dhit_count", n_dhit - b_dhit, 0);

    // Collision: data first, one idle cycle, then fetch.
    do_reset();
    b_hq = hit_q.size();
    auto_rel = 1;
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100; ramREADY = 1;
    repeat (8) step();
    sample();
    chk("t2_hit_count", hit_q.size() - b_hq, 2);
    if (hit_q.size() - b_hq >= 2) begin
      chk("t2_first", hit_q[b_hq], "D");
      chk("t2_second", hit_q[b_hq + 1], "I");
      chk("t2_gap", hit_cyc[b_hq + 1] - hit_cyc[b_hq], 2);
    end

    // Write precedence when both read and write are requested.
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    step();
    sample();
    chk("t3_ramWEN", ramWEN, 1);
    chk("t3_ramREN", ramREN, 0);
    chk("t3_ramstore", ramstore, 32'hDEADBEEF);
    chk("t3_ramaddr", ramaddr, 32'h200);
    chk("t3_no_early_hit", dhit, 0);
    ramREADY = 1;
    #1;
    chk("t3_dhit", dhit, 1);
    step();
    dREN = 0; dWEN = 0; ramREADY = 0;
    step();

    // Starvation: fetch forced after STARVE_MAX data grants.
    do_reset();
    b_hq = hit_q.size();
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h400; ramREADY = 1;
    repeat (20) step();
    sample();
    exp_order = "DDDDIDDDDI";
    chk("t4_hit_count", hit_q.size() - b_hq, 10);
    if (hit_q.size() - b_hq >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("t4_order%0d", i), hit_q[b_hq + i], exp_order[i]);

    // Watchdog: RAM never ready.
    do_reset();
    b_ren = n_ren; b_dhit = n_dhit;
    dREN = 1; daddr = 32'h500;
    for (int k = 0; k < 100; k++) begin
      step();
      sample();
      if (bus_err) break;
    end
    dREN = 0;
    chk("t5_bus_err", bus_err, 1);
    chk("t5_ren_cycles", n_ren - b_ren, TO);
    chk("t5_ramREN_dropped", ramREN, 0);
    repeat (10) step();
    sample();
    chk("t5_sticky", bus_err, 1);
    chk("t5_no_dhit", n_dhit - b_dhit, 0);
    RST = 1; step(); RST = 0;
    sample();
    chk("t5_cleared", bus_err, 0);

    // Reset on the 2nd fetch grant cycle.
    do_reset();
    b_ihit = n_ihit;
    iREN = 1; iaddr = 32'h600;
    step(); step();
    RST = 1; iREN = 0;
    step();
    RST = 0;
    sample();
    chk("t6_ramREN", ramREN, 0);
    chk("t6_ramaddr", ramaddr, 0);
    chk("t6_ihit", n_ihit - b_ihit, 0);
    chk("t6_bus_err", bus_err, 0);
    // With counters cleared, a collision must go to data first.
    b_hq = hit_q.size();
    auto_rel = 1; iREN = 1; dREN = 1; ramREADY = 1;
    repeat (4) step();
    sample();
    chk("t6_after_hits", hit_q.size() - b_hq, 2);
    if (hit_q.size() - b_hq >= 1) chk("t6_after_first", hit_q[b_hq], "D");

    // Randomized traffic against the model.
    do_reset();
    auto_rel = 1; rnd = 1;
    repeat (3000) step();
    rnd = 0; RST = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
